// File: rtl/count_seq_pkg.sv
// Shared state encoding and default sizing for the count sequencer and its datapath.
package count_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_PRESCALE_W = 4;
    localparam int COUNT_INCR     = 1;

endpackage

// File: rtl/count_datapath.sv
// Counter datapath: ripple-carry adder (count + increment) feeding a register with
// synchronous clear and enable. The adder carry-out is never formed.
module count_datapath
    import count_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             enable_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] carry;

    assign addend   = WIDTH'(COUNT_INCR);
    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_sum
        assign sum[i] = count_q[i] ^ addend[i] ^ carry[i];
    end

    // The carry out of the top bit is deliberately not built; the sequencer reloads before overflow.
    for (genvar i = 0; i < WIDTH - 1; i++) begin : g_carry
        assign carry[i+1] = (count_q[i] & addend[i]) | (carry[i] & (count_q[i] ^ addend[i]));
    end

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = sum;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/count_sequencer.sv
// Start/stop sequencer around count_datapath: prescaler, programmable terminal count,
// one-shot or auto-reload operation, and registered TICK/DONE pulses.
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic                  periodic_i,
    input  logic [WIDTH-1:0]      period_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic [WIDTH-1:0]      o_o,
    output logic                  busy_o,
    output logic                  tick_o,
    output logic                  done_o
);

    state_e                state_q, state_d;
    logic [PRESCALE_W-1:0] pre_q, pre_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [WIDTH-1:0]      period_q, period_d;
    logic                  periodic_q, periodic_d;
    logic                  tick_q, tick_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  dp_clear;
    logic                  dp_enable;
    logic [WIDTH-1:0]      count;
    logic                  pre_wrap;
    logic                  terminal;

    count_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (dp_clear),
        .enable_i(dp_enable),
        .count_o (count)
    );

    assign pre_wrap = (pre_q == prescale_q);
    assign terminal = pre_wrap && (count == period_q);

    // STOP outranks the terminal event in RUN, so an abort never emits a TICK.
    always_comb begin
        state_d    = state_q;
        pre_d      = pre_q;
        prescale_d = prescale_q;
        period_d   = period_q;
        periodic_d = periodic_q;
        tick_d     = 1'b0;
        done_d     = 1'b0;
        dp_clear   = 1'b0;
        dp_enable  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i && !stop_i) begin
                    state_d    = ARM;
                    period_d   = period_i;
                    prescale_d = prescale_i;
                    periodic_d = periodic_i;
                    pre_d      = '0;
                    dp_clear   = 1'b1;
                end
            end
            ARM: begin
                if (stop_i) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop_i) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (terminal) begin
                    tick_d   = 1'b1;
                    pre_d    = '0;
                    dp_clear = 1'b1;
                    if (!periodic_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else if (pre_wrap) begin
                    pre_d     = '0;
                    dp_enable = 1'b1;
                end else begin
                    pre_d = pre_q + PRESCALE_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            pre_q      <= '0;
            prescale_q <= '0;
            period_q   <= '0;
            periodic_q <= 1'b0;
            tick_q     <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            prescale_q <= prescale_d;
            period_q   <= period_d;
            periodic_q <= periodic_d;
            tick_q     <= tick_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign o_o    = count;
    assign busy_o = busy_q;
    assign tick_o = tick_q;
    assign done_o = done_q;

endmodule

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
- Controller and sequencer for the team's N-bit ripple-carry counter datapath (adder plus register).
- Adds start/stop control, a programmable terminal count (PERIOD), a clock prescaler, and one-shot or auto-reload modes.
- Emits single-cycle TICK/DONE pulses for downstream logic, e.g. LED strobes and UART baud timing on the icestick top level.
- Sits between the top-level main and the counter datapath; the counter never free-runs unless this block enables it.

Parameters:
- WIDTH, 8: counter, PERIOD and O width.
- PRESCALE_W, 4: prescaler field and prescale counter width.

Ports:
- CLK  in  1  sole clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  begin a run; sampled only in IDLE.
- STOP  in  1  abort the run; sampled in ARM and RUN.
- PERIODIC  in  1  1 = auto-reload, 0 = one-shot; latched at START.
- PERIOD  in  WIDTH  terminal count value; latched at START.
- PRESCALE  in  PRESCALE_W  count advances every PRESCALE+1 cycles; latched at START.
- O  out  WIDTH  current count value.
- BUSY  out  1  high in ARM and RUN.
- TICK  out  1  one-cycle pulse, cycle after each terminal event.
- DONE  out  1  one-cycle pulse, cycle after one-shot completion or STOP abort.

Behaviour:
- Reset (async, any state): state=IDLE, O=0, prescale counter=0, latched fields=0, BUSY=0, TICK=0, DONE=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- IDLE:
  - START=1 and STOP=0 -> go to ARM. Latch PERIOD, PRESCALE, PERIODIC; O<=0; prescale counter<=0.
  - START and STOP both high -> stay in IDLE.
- ARM: one cycle, always -> RUN. STOP=1 here -> IDLE with DONE pulse.
- RUN, evaluated at each edge in priority order:
  1. STOP=1 -> IDLE, DONE<=1, TICK stays 0, O holds its value, even if the terminal condition is true the same cycle.
  2. Terminal T = (pre==PRESCALE_l) and (O==PERIOD_l). On T: TICK<=1, O<=0, pre<=0.
     - PERIODIC_l=1: stay in RUN.
     - PERIODIC_l=0: -> IDLE, DONE<=1.
  3. pre==PRESCALE_l without T: pre<=0, O<=O+1 via the datapath adder (carry-in 0, I1=1).
  4. Otherwise pre<=pre+1, O holds.
- Latency: START sampled at edge 0 -> ARM in cycle 1 -> RUN from cycle 2 with O=0.
  - First TICK is high in cycle 2+(PERIOD+1)*(PRESCALE+1).
  - In periodic mode, later TICKs follow every (PERIOD+1)*(PRESCALE+1) cycles with no gap cycle.
- PERIOD=0, PRESCALE=0: TICK every cycle in periodic mode (continuous high).
- PERIOD=all-ones: O reaches max, then the terminal reload to 0. O never wraps through the adder carry-out, and COUT is unused.
- START while BUSY is ignored. Changes to PERIOD/PRESCALE/PERIODIC during a run have no effect until the next START.
- DONE and TICK are both high in the same cycle on one-shot completion. After a STOP abort only DONE is high.

Decomposition:
- Package count_seq_pkg holds:
  - state encoding IDLE=2'd0, ARM=2'd1, RUN=2'd2;
  - default WIDTH/PRESCALE_W constants;
  - the increment constant (1).
- One sub-module, count_datapath: WIDTH-bit register with synchronous clear and enable, fed by the adder chain (I0=O, I1=1).
- count_sequencer holds the FSM, the prescale counter, the latches and the pulse registers, and drives clear/enable of count_datapath.

Test Plan:
- Reset mid-run (PERIODIC=1, O=5): assert RESET asynchronously between edges -> O=0, BUSY=0, TICK=0 immediately. No activity until the next START.
- One-shot: PERIOD=3, PRESCALE=0, START pulse at cycle 0 ->
  - BUSY=1 in cycles 1-5;
  - O=0,0,1,2,3 in cycles 1-5;
  - cycle 6: TICK=1, DONE=1, BUSY=0, O=0.
- Periodic with prescale: PERIOD=2, PRESCALE=1 -> TICK in cycles 8, 14, 20 …, each one cycle wide. O steps 0,0,1,1,2,2 between ticks.
- STOP collision: PERIOD=3, PRESCALE=0, STOP asserted in cycle 5, the terminal cycle -> cycle 6: DONE=1, TICK=0, O=3, state IDLE.
- Ignored inputs:
  - START re-asserted in cycle 3 of a run -> no restart, timing unchanged.
  - PERIOD changed to 7 mid-run -> still terminates at 3.
  - START and STOP together in IDLE -> BUSY stays 0.
- Boundaries:
  - PERIOD=255, PRESCALE=0, one-shot -> O climbs to 255 and DONE appears in cycle 258.
  - PERIOD=0, PRESCALE=0, periodic -> TICK=1 in every cycle from cycle 3 on.
